// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl
//   Clock/reset sequencer for the cpu68 core and its bus peripherals.
//   Debounces the raw step and run buttons and produces the registered CPU
//   clock sys_clk. It is either single-stepped (one full period per step
//   press) or free-running. sys_res is held for RES_CYCLES sys_clk rises after
//   reset and released on a sys_clk falling edge. cyc_cnt counts sys_clk rises
//   once the CPU is out of reset and feeds the LED/seven-segment debug path.
//
// Ports
//   clk_in       in   1      board clock, all logic on posedge
//   b_reset      in   1      asynchronous reset, active-low
//   b_step       in   1      raw step button, active-low
//   b_run        in   1      raw run/step mode button, active-low
//   sys_clk      out  1      CPU clock, registered
//   sys_clk_rise out  1      one clk_in pulse in the cycle sys_clk becomes 1
//   sys_res      out  1      CPU reset, active-high
//   run_mode     out  1      1 = free-run, 0 = single-step
//   cyc_cnt      out  CNT_W  sys_clk rises counted while sys_res = 0
module cpu_clk_ctrl #(
  parameter int DB_CYCLES  = 120000,
  parameter int HALF_DIV   = 6,
  parameter int RES_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_in,
  input  logic             b_reset,
  input  logic             b_step,
  input  logic             b_run,
  output logic             sys_clk,
  output logic             sys_clk_rise,
  output logic             sys_res,
  output logic             run_mode,
  output logic [CNT_W-1:0] cyc_cnt
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam int PH_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int RC_W = $clog2(RES_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_DIV - 1);
  localparam logic [RC_W-1:0] RC_DONE = RC_W'(RES_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  // Bit 0 carries the step button, bit 1 the run button.
  logic [1:0]      btn_raw;
  logic [1:0]      sync_p0;
  logic [1:0]      sync_p1;
  logic [1:0]      stable;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  logic            step_evt;
  logic            run_evt;

  state_t          state;
  state_t          state_nxt;
  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_nxt;
  logic            clk_nxt;
  logic            rise_nxt;
  logic            fall_nxt;
  logic [RC_W-1:0] rcnt;

  assign btn_raw  = {b_run, b_step};
  assign step_evt = press[0];
  assign run_evt  = press[1];

  // ---- stage: 2-FF synchroniser, then debouncer and press detect ----
  // The counter only runs while the synchronised level disagrees with the
  // accepted level, so any bounce back to the accepted level restarts it.
  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
      stable  <= '1;
      press   <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_p1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          stable[i] <= sync_p1[i];
          // Old accepted level 1 means this is a press; releases stay silent.
          press[i]  <= stable[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // ---- stage: clock generator FSM ----
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    clk_nxt   = sys_clk;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      IDLE: begin
        clk_nxt = 1'b0;
        // A run toggle in the same cycle wins over a step press.
        if (run_mode || (step_evt && !run_evt)) begin
          state_nxt = HI;
          phase_nxt = '0;
          clk_nxt   = 1'b1;
          rise_nxt  = 1'b1;
        end
      end
      HI: begin
        if (phase == PH_LAST) begin
          state_nxt = LO;
          phase_nxt = '0;
          clk_nxt   = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          phase_nxt = phase + PH_W'(1);
          clk_nxt   = 1'b1;
        end
      end
      LO: begin
        clk_nxt = 1'b0;
        if (phase == PH_LAST) begin
          phase_nxt = '0;
          // run_mode is only sampled here, so leaving free-run always lets
          // the current period finish at full length.
          if (run_mode) begin
            state_nxt = HI;
            clk_nxt   = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
        clk_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      state        <= IDLE;
      phase        <= '0;
      sys_clk      <= 1'b0;
      sys_clk_rise <= 1'b0;
      run_mode     <= 1'b0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      sys_clk      <= clk_nxt;
      sys_clk_rise <= rise_nxt;
      run_mode     <= run_mode ^ run_evt;
    end
  end

  // ---- stage: reset sequencing and cycle counter ----
  // sys_res only drops together with a sys_clk fall, so the CPU never sees
  // reset release close to its active edge.
  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      rcnt    <= '0;
      sys_res <= 1'b1;
      cyc_cnt <= '0;
    end else begin
      if (rise_nxt && sys_res && (rcnt != RC_DONE)) rcnt <= rcnt + RC_W'(1);
      if (fall_nxt && (rcnt == RC_DONE)) sys_res <= 1'b0;
      if (rise_nxt && !sys_res) cyc_cnt <= cyc_cnt + CNT_W'(1);
    end
  end

endmodule
